collision_matrix: RTL and testbench
===================================

COLLISION_MATRIX -- requirements
Module: collision_matrix

Interface
REQ-001 Parameter N_OBST: default 4, range 1..16; number of obstacle draw channels.
REQ-002 Parameter CNT_W: default 8, range 4..16; width of the per-frame overlap-pixel counter.
REQ-003 clk  input  1  pixel clock; the only clock.
REQ-004 resetN  input  1  reset; synchronous, active-low.
REQ-005 startOfFrame  input  1  one-cycle frame-boundary strobe.
REQ-006 draw_smiley  input  1  ball pixel active this cycle.
REQ-007 draw_border  input  4  border pixel active; bit0 top, bit1 bottom, bit2 left, bit3 right.
REQ-008 draw_flipper  input  1  flipper pixel active.
REQ-009 drawObstacle  input  N_OBST  per-obstacle pixel active.
REQ-010 col_ball_border  output  4  ball/border collision pulses, same bit order as draw_border.
REQ-011 col_ball_flipper  output  1  ball/flipper collision pulse.
REQ-012 col_flipper_border  output  2  flipper/border pulses; bit0 left, bit1 right.
REQ-013 col_ball_obst  output  N_OBST  per-obstacle ball collision pulses.
REQ-014 obst_hit_valid  output  1  any bit of col_ball_obst set.
REQ-015 obst_hit_id  output  max(1,clog2(N_OBST))  lowest set index of col_ball_obst; 0 when not valid.
REQ-016 overlap_pixels  output  CNT_W  ball-on-any-obstacle pixel count of the completed frame; held until next publish.

Function
REQ-017 Each cycle, the block SHALL compute hit terms: ball&border[i], ball&flipper, flipper&border[2], flipper&border[3], ball&obstacle[k].
REQ-018 Sticky accumulators SHALL OR the hit terms over a frame; the overlap counter SHALL increment once per cycle in which ball overlaps any obstacle, saturating at 2^CNT_W-1.
REQ-019 On a startOfFrame cycle, the block SHALL publish the accumulators, then load them with that cycle's hit terms only (that cycle belongs to the new frame), and load the counter with 1 or 0 accordingly.
REQ-020 Published pulse outputs SHALL be high for exactly the one cycle after startOfFrame (latency 1) and 0 otherwise.
REQ-021 overlap_pixels SHALL update in the cycle after startOfFrame and hold its value between publishes.
REQ-022 obst_hit_id SHALL be registered together with col_ball_obst; with simultaneous obstacle hits, the lowest index SHALL win.
REQ-023 Back-to-back startOfFrame strobes SHALL publish a one-cycle frame normally, with no lost or merged data.
REQ-024 Before the first startOfFrame after reset, all pulse outputs SHALL stay 0.

Reset
REQ-025 While resetN=0 at a clk edge, the block SHALL clear all accumulators, the counter, all outputs, and the previous-frame obstacle register to 0.
REQ-026 A reset asserted mid-frame SHALL discard that partial frame; the next publish SHALL reflect only post-reset cycles.

Configuration
REQ-027 With macro COLLISION_OBST_EDGE_EN defined, col_ball_obst[k] SHALL pulse only when obstacle k was hit this frame and was not hit in the previous published frame (new-contact only).
REQ-028 Without COLLISION_OBST_EDGE_EN, col_ball_obst[k] SHALL pulse for every frame in which obstacle k was hit.
REQ-029 With or without the macro, the remaining outputs and overlap_pixels SHALL be unaffected, and obst_hit_valid/obst_hit_id SHALL derive from the filtered col_ball_obst.

Structure
REQ-030 Package collision_pkg SHALL hold the border index constants (TOP=0, BOTTOM=1, LEFT=2, RIGHT=3), N_OBST_MAX=16, and a typedef for the 4-bit border vector.
REQ-031 The block SHALL contain exactly one sub-module: obst_prio_enc, a parametrised lowest-index priority encoder producing valid and id.

Verification
REQ-032 Ball overlaps the top border for 5 pixels in frame 1 -> col_ball_border=4'b0001 for one cycle after the next startOfFrame; 4'b0000 after a frame with no overlap.
REQ-033 N_OBST=4; ball overlaps obstacles 1 and 3 in the same frame -> col_ball_obst=4'b1010, obst_hit_valid=1, obst_hit_id=1.
REQ-034 CNT_W=4; 20 overlap cycles in one frame -> overlap_pixels=15 (saturated); next frame with 3 overlap cycles -> 3.
REQ-035 Edge mode: obstacle 2 is hit in frames 1, 2, and 4 -> with COLLISION_OBST_EDGE_EN, pulses after frames 1 and 4 only; without it, pulses after frames 1, 2, and 4.
REQ-036 Overlap occurs exactly on the startOfFrame cycle -> not reported at that publish; reported at the following publish.
REQ-037 resetN=0 for 1 cycle mid-frame after an overlap -> all outputs 0, and the next publish shows no collision.

Source files
------------

// File: rtl/collision_pkg.sv
// Shared constants and types for the collision matrix: border bit positions,
// the obstacle-count ceiling, and the border vector type.
package collision_pkg;

  localparam int TOP        = 0;
  localparam int BOTTOM     = 1;
  localparam int LEFT       = 2;
  localparam int RIGHT      = 3;
  localparam int N_OBST_MAX = 16;

  typedef logic [3:0] border_t;

endpackage

// File: rtl/collision_matrix_obst_prio_enc.sv
// Lowest-index priority encoder: reports whether any request is set and the
// index of the lowest set request (0 when none).
module obst_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] id
);

  // Scanning from the top down lets the lowest set index overwrite last.
  always_comb begin
    valid = |req;
    id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) id = W'(i);
    end
  end

endmodule

// File: rtl/collision_matrix.sv
// Per-frame collision accumulator for ball, borders, flipper and obstacles.
// Define COLLISION_OBST_EDGE_EN to report only new obstacle contacts.
module collision_matrix
  import collision_pkg::*;
#(
  parameter  int N_OBST = 4,
  parameter  int CNT_W  = 8,
  localparam int ID_W   = (N_OBST > 1) ? $clog2(N_OBST) : 1
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              startOfFrame,
  input  logic              draw_smiley,
  input  border_t           draw_border,
  input  logic              draw_flipper,
  input  logic [N_OBST-1:0] drawObstacle,
  output border_t           col_ball_border,
  output logic              col_ball_flipper,
  output logic [1:0]        col_flipper_border,
  output logic [N_OBST-1:0] col_ball_obst,
  output logic              obst_hit_valid,
  output logic [ID_W-1:0]   obst_hit_id,
  output logic [CNT_W-1:0]  overlap_pixels
);

  border_t           hit_border, acc_border;
  logic              hit_bf, acc_bf;
  logic [1:0]        hit_fb, acc_fb;
  logic [N_OBST-1:0] hit_obst, acc_obst, pub_obst;
  logic              ball_on_obst;
  logic [CNT_W-1:0]  acc_cnt;
  logic              enc_valid;
  logic [ID_W-1:0]   enc_id;

  always_comb begin
    hit_border   = draw_border & {4{draw_smiley}};
    hit_bf       = draw_smiley & draw_flipper;
    hit_fb       = {draw_flipper & draw_border[RIGHT], draw_flipper & draw_border[LEFT]};
    hit_obst     = drawObstacle & {N_OBST{draw_smiley}};
    ball_on_obst = |hit_obst;
  end

`ifdef COLLISION_OBST_EDGE_EN
  // Remembers the unfiltered obstacle hits of the last published frame.
  logic [N_OBST-1:0] prev_obst;

  always_ff @(posedge clk) begin
    if (!resetN)           prev_obst <= '0;
    else if (startOfFrame) prev_obst <= acc_obst;
  end

  assign pub_obst = acc_obst & ~prev_obst;
`else
  assign pub_obst = acc_obst;
`endif

  obst_prio_enc #(.N(N_OBST), .W(ID_W)) u_enc (
    .req   (pub_obst),
    .valid (enc_valid),
    .id    (enc_id)
  );

  // The strobe cycle publishes the old frame and seeds the new one with its own hits.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      acc_border         <= '0;
      acc_bf             <= 1'b0;
      acc_fb             <= '0;
      acc_obst           <= '0;
      acc_cnt            <= '0;
      col_ball_border    <= '0;
      col_ball_flipper   <= 1'b0;
      col_flipper_border <= '0;
      col_ball_obst      <= '0;
      obst_hit_valid     <= 1'b0;
      obst_hit_id        <= '0;
      overlap_pixels     <= '0;
    end else if (startOfFrame) begin
      col_ball_border    <= acc_border;
      col_ball_flipper   <= acc_bf;
      col_flipper_border <= acc_fb;
      col_ball_obst      <= pub_obst;
      obst_hit_valid     <= enc_valid;
      obst_hit_id        <= enc_id;
      overlap_pixels     <= acc_cnt;
      acc_border         <= hit_border;
      acc_bf             <= hit_bf;
      acc_fb             <= hit_fb;
      acc_obst           <= hit_obst;
      acc_cnt            <= CNT_W'(ball_on_obst);
    end else begin
      col_ball_border    <= '0;
      col_ball_flipper   <= 1'b0;
      col_flipper_border <= '0;
      col_ball_obst      <= '0;
      obst_hit_valid     <= 1'b0;
      obst_hit_id        <= '0;
      acc_border         <= acc_border | hit_border;
      acc_bf             <= acc_bf | hit_bf;
      acc_fb             <= acc_fb | hit_fb;
      acc_obst           <= acc_obst | hit_obst;
      if (ball_on_obst && (acc_cnt != {CNT_W{1'b1}})) acc_cnt <= acc_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_collision_matrix.sv
// Scoreboard bench for collision_matrix: a per-frame counting model predicts
// every cycle's outputs; a negedge monitor pops and compares them.
module tb_collision_matrix;

  localparam int N_OBST  = 4;
  localparam int CNT_W   = 4;
  localparam int ID_W    = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              resetN = 1'b0;
  logic              startOfFrame = 1'b0;
  logic              draw_smiley = 1'b0;
  logic [3:0]        draw_border = '0;
  logic              draw_flipper = 1'b0;
  logic [N_OBST-1:0] drawObstacle = '0;
  logic [3:0]        col_ball_border;
  logic              col_ball_flipper;
  logic [1:0]        col_flipper_border;
  logic [N_OBST-1:0] col_ball_obst;
  logic              obst_hit_valid;
  logic [ID_W-1:0]   obst_hit_id;
  logic [CNT_W-1:0]  overlap_pixels;

  typedef struct packed {
    logic [3:0]        border;
    logic              bf;
    logic [1:0]        fb;
    logic [N_OBST-1:0] obst;
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [CNT_W-1:0]  overlap;
  } resp_t;

  resp_t exp_q[$];
  int    n_checks = 0;
  int    n_pass = 0;

  int cnt_border[4];
  int cnt_bf;
  int cnt_fb[2];
  int cnt_obst[N_OBST];
  int cnt_overlap;
  bit prev_hit[N_OBST];
  int held_overlap = 0;

  collision_matrix #(.N_OBST(N_OBST), .CNT_W(CNT_W)) dut (
    .clk                (clk),
    .resetN             (resetN),
    .startOfFrame       (startOfFrame),
    .draw_smiley        (draw_smiley),
    .draw_border        (draw_border),
    .draw_flipper       (draw_flipper),
    .drawObstacle       (drawObstacle),
    .col_ball_border    (col_ball_border),
    .col_ball_flipper   (col_ball_flipper),
    .col_flipper_border (col_flipper_border),
    .col_ball_obst      (col_ball_obst),
    .obst_hit_valid     (obst_hit_valid),
    .obst_hit_id        (obst_hit_id),
    .overlap_pixels     (overlap_pixels)
  );

  always #5 clk = ~clk;

  task automatic clear_frame();
    for (int i = 0; i < 4; i++) cnt_border[i] = 0;
    for (int i = 0; i < 2; i++) cnt_fb[i] = 0;
    for (int k = 0; k < N_OBST; k++) cnt_obst[k] = 0;
    cnt_bf = 0;
    cnt_overlap = 0;
  endtask

  task automatic account_cycle(input logic ball, input logic [3:0] border,
                               input logic flip, input logic [N_OBST-1:0] obst);
    for (int i = 0; i < 4; i++) if (ball && border[i]) cnt_border[i]++;
    if (ball && flip) cnt_bf++;
    if (flip && border[2]) cnt_fb[0]++;
    if (flip && border[3]) cnt_fb[1]++;
    for (int k = 0; k < N_OBST; k++) if (ball && obst[k]) cnt_obst[k]++;
    if (ball && (obst != '0)) cnt_overlap++;
  endtask

  // One clock of stimulus; the expected outputs after that edge go to the queue.
  task automatic apply_stimulus(input logic sof, input logic ball, input logic [3:0] border,
                                input logic flip, input logic [N_OBST-1:0] obst,
                                input logic rstn);
    resp_t e;
    bit    hit;
    @(negedge clk);
    resetN       = rstn;
    startOfFrame = sof;
    draw_smiley  = ball;
    draw_border  = border;
    draw_flipper = flip;
    drawObstacle = obst;
    @(posedge clk);
    e = '0;
    if (!rstn) begin
      clear_frame();
      for (int k = 0; k < N_OBST; k++) prev_hit[k] = 1'b0;
      held_overlap = 0;
    end else if (sof) begin
      for (int i = 0; i < 4; i++) e.border[i] = (cnt_border[i] > 0);
      e.bf = (cnt_bf > 0);
      for (int i = 0; i < 2; i++) e.fb[i] = (cnt_fb[i] > 0);
      for (int k = 0; k < N_OBST; k++) begin
        hit = (cnt_obst[k] > 0);
`ifdef COLLISION_OBST_EDGE_EN
        e.obst[k] = hit && !prev_hit[k];
`else
        e.obst[k] = hit;
`endif
        prev_hit[k] = hit;
      end
      for (int k = 0; k < N_OBST; k++) begin
        if (e.obst[k] && !e.valid) begin
          e.valid = 1'b1;
          e.id    = ID_W'(k);
        end
      end
      held_overlap = (cnt_overlap > CNT_MAX) ? CNT_MAX : cnt_overlap;
      e.overlap = CNT_W'(held_overlap);
      clear_frame();
      account_cycle(ball, border, flip, obst);
    end else begin
      account_cycle(ball, border, flip, obst);
      e.overlap = CNT_W'(held_overlap);
    end
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic sof, input logic ball, input logic [3:0] border,
                     input logic flip, input logic [N_OBST-1:0] obst);
    apply_stimulus(sof, ball, border, flip, obst, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'b0000, 1'b0, '0);
  endtask

  task automatic check_output(input resp_t e);
    resp_t a;
    a = {col_ball_border, col_ball_flipper, col_flipper_border, col_ball_obst,
         obst_hit_valid, obst_hit_id, overlap_pixels};
    n_checks++;
    if (a === e) n_pass++;
    else $display("[TB] FAIL outputs @%0t: got bb=%b bf=%b fb=%b obst=%b v=%b id=%0d ov=%0d, expected bb=%b bf=%b fb=%b obst=%b v=%b id=%0d ov=%0d",
                  $time, a.border, a.bf, a.fb, a.obst, a.valid, a.id, a.overlap,
                  e.border, e.bf, e.fb, e.obst, e.valid, e.id, e.overlap);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) check_output(exp_q.pop_front());
    end
  end

  initial begin
    logic [3:0]        rb;
    logic [N_OBST-1:0] ro;
    int                len;
    clear_frame();
    for (int k = 0; k < N_OBST; k++) prev_hit[k] = 1'b0;

    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 4'b0000, 1'b0, '0, 1'b0);
    // Hits before the first strobe must not pulse anything.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4'b0000, 1'b0, 4'b0001);

    // Ball on top border for 5 pixels, then an empty frame.
    cyc(1'b1, 1'b0, 4'b0000, 1'b0, '0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 4'b0001, 1'b0, '0);
    cyc(1'b1, 1'b0, 4'b0000, 1'b0, '0);
    idle(4);

    // Obstacles 1 and 3 in the same frame.
    cyc(1'b1, 1'b0, 4'b0000, 1'b0, '0);
    cyc(1'b0, 1'b1, 4'b0000, 1'b0, 4'b0010);
    cyc(1'b0, 1'b1, 4'b0000, 1'b0, 4'b1000);
    idle(2);

    // Saturating counter: 20 overlaps, then 3.
    cyc(1'b1, 1'b0, 4'b0000, 1'b0, '0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 4'b0000, 1'b0, 4'b0001);
    cyc(1'b1, 1'b0, 4'b0000, 1'b0, '0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4'b0000, 1'b0, 4'b0100);
    idle(2);

    // Overlap exactly on the strobe cycle belongs to the new frame.
    cyc(1'b1, 1'b1, 4'b0000, 1'b0, 4'b0100);
    idle(2);
    cyc(1'b1, 1'b0, 4'b0000, 1'b0, '0);
    idle(2);

    // Back-to-back strobes carrying hits.
    cyc(1'b1, 1'b1, 4'b0000, 1'b1, '0);
    cyc(1'b1, 1'b0, 4'b0100, 1'b1, '0);
    cyc(1'b1, 1'b0, 4'b1000, 1'b1, '0);
    cyc(1'b1, 1'b0, 4'b0000, 1'b0, '0);

    // Obstacle 2 hit in frames 1, 2 and 4.
    for (int f = 1; f <= 4; f++) begin
      cyc(1'b1, 1'b0, 4'b0000, 1'b0, '0);
      if (f != 3) cyc(1'b0, 1'b1, 4'b0000, 1'b0, 4'b0100);
      idle(2);
    end
    cyc(1'b1, 1'b0, 4'b0000, 1'b0, '0);
    idle(1);

    // Mid-frame reset discards the partial frame.
    cyc(1'b1, 1'b0, 4'b0000, 1'b0, '0);
    cyc(1'b0, 1'b1, 4'b0011, 1'b1, 4'b1111);
    apply_stimulus(1'b0, 1'b0, 4'b0000, 1'b0, '0, 1'b0);
    idle(2);
    cyc(1'b1, 1'b0, 4'b0000, 1'b0, '0);
    idle(1);
    cyc(1'b1, 1'b0, 4'b0000, 1'b0, '0);
    idle(1);

    // Randomized frames with occasional long frames and resets.
    for (int f = 0; f < 60; f++) begin
      len = ($urandom_range(0, 5) == 0) ? $urandom_range(16, 30) : $urandom_range(1, 8);
      for (int c = 0; c < len; c++) begin
        for (int i = 0; i < 4; i++) rb[i] = ($urandom_range(0, 9) < 3);
        for (int k = 0; k < N_OBST; k++) ro[k] = ($urandom_range(0, 9) < 3);
        apply_stimulus(c == 0, $urandom_range(0, 9) < 6, rb, $urandom_range(0, 1) == 1, ro,
                       $urandom_range(0, 79) != 0);
      end
    end
    cyc(1'b1, 1'b0, 4'b0000, 1'b0, '0);
    idle(1);

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
